// File: rtl/multi_edge_sync_pkg.sv
// Shared types and defaults for the multi-channel synchroniser / edge detector.
package multi_edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILTER_LEN  = 1;
  localparam int unsigned DEF_CNT_W       = 8;

  // True when a transition to new_level is an event under the given mode.
  function automatic logic edge_match(edge_mode_e mode, logic new_level);
    case (mode)
      EDGE_RISE: return new_level;
      EDGE_FALL: return ~new_level;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchroniser chain, stability filter, edge detect, sticky flag
// and saturating event counter, all in the outclk domain.
module sync_filter_ch
  import multi_edge_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
  parameter edge_mode_e  EDGE_MODE   = EDGE_RISE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             outclk,
  input  logic             rst_n,
  input  logic             async_sig,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic             sync_level,
  output logic             edge_pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] evt_count
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_filter_ch: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("sync_filter_ch: FILTER_LEN must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sync_filter_ch: CNT_W must be >= 1");
  end

  localparam int unsigned       FCNT_W    = $clog2(FILTER_LEN) + 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [FCNT_W-1:0]      r_fcnt;
  logic                   r_pulse;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_cnt;

  logic w_s_last;
  logic w_differs;
  logic w_accept;
  logic w_event;

  assign w_s_last  = r_sync[SYNC_STAGES-1];
  assign w_differs = w_s_last ^ r_filt;
  assign w_accept  = w_differs && (r_fcnt == FCNT_LAST);
  assign w_event   = w_accept && edge_match(EDGE_MODE, w_s_last);

  // Plain flop chain, nothing between stages.
  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_sig};
    end
  end

  // Any return to the accepted level restarts the persistence count.
  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (!w_differs) begin
      r_fcnt <= '0;
    end else if (w_accept) begin
      r_filt <= w_s_last;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FCNT_ONE;
    end
  end

  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_pulse  <= w_event;
      r_sticky <= w_event | (r_sticky & ~clr);
    end
  end

  // A clear that coincides with an event leaves that event counted.
  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= w_event ? CNT_ONE : '0;
    end else if (w_event && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign sync_level = r_filt;
  assign edge_pulse = r_pulse;
  assign sticky     = r_sticky;
  assign evt_count  = r_cnt;

endmodule

// File: rtl/multi_edge_sync.sv
// Multi-channel synchroniser and edge-event detector; fans ports out to one
// sync_filter_ch per channel and packs the event counters.
module multi_edge_sync
  import multi_edge_sync_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
  parameter edge_mode_e  EDGE_MODE   = EDGE_RISE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                    outclk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       async_sig,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       sync_level,
  output logic [NUM_CH-1:0]       edge_pulse,
  output logic [NUM_CH-1:0]       sticky,
  output logic [NUM_CH*CNT_W-1:0] evt_count
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("multi_edge_sync: NUM_CH must be >= 1");
  end

  logic [CNT_W-1:0] w_cnt [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .EDGE_MODE   (EDGE_MODE),
      .CNT_W       (CNT_W)
    ) u_ch (
      .outclk     (outclk),
      .rst_n      (rst_n),
      .async_sig  (async_sig[i]),
      .clr        (clr[i]),
      .cnt_clr    (cnt_clr),
      .sync_level (sync_level[i]),
      .edge_pulse (edge_pulse[i]),
      .sticky     (sticky[i]),
      .evt_count  (w_cnt[i])
    );
  end

  always_comb begin
    evt_count = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      evt_count[i*CNT_W +: CNT_W] = w_cnt[i];
    end
  end

endmodule

// File: tb/tb_multi_edge_sync.sv
// Self-checking bench: four configurations of multi_edge_sync against a
// window-based behavioural model, plus directed scenario checks.
module tb_multi_edge_sync;
  import multi_edge_sync_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Channel map: 0..3 = u_r (4 ch), 4 = u_f, 5 = u_a, 6 = u_b
  logic [6:0] a_drv  = '0;
  logic [6:0] cl_drv = '0;
  logic [3:0] cc_drv = '0;

  logic [3:0]  lvl_r, pls_r, stk_r;
  logic [11:0] cnt_r;
  logic        lvl_f, pls_f, stk_f, lvl_a, pls_a, stk_a, lvl_b, pls_b, stk_b;
  logic [7:0]  cnt_f, cnt_a, cnt_b;

  multi_edge_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(EDGE_RISE), .CNT_W(3)) u_r (
    .outclk(clk), .rst_n(rst_n), .async_sig(a_drv[3:0]), .clr(cl_drv[3:0]), .cnt_clr(cc_drv[0]),
    .sync_level(lvl_r), .edge_pulse(pls_r), .sticky(stk_r), .evt_count(cnt_r));
  multi_edge_sync #(.NUM_CH(1), .SYNC_STAGES(2), .FILTER_LEN(4), .EDGE_MODE(EDGE_RISE), .CNT_W(8)) u_f (
    .outclk(clk), .rst_n(rst_n), .async_sig(a_drv[4]), .clr(cl_drv[4]), .cnt_clr(cc_drv[1]),
    .sync_level(lvl_f), .edge_pulse(pls_f), .sticky(stk_f), .evt_count(cnt_f));
  multi_edge_sync #(.NUM_CH(1), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(EDGE_FALL), .CNT_W(8)) u_a (
    .outclk(clk), .rst_n(rst_n), .async_sig(a_drv[5]), .clr(cl_drv[5]), .cnt_clr(cc_drv[2]),
    .sync_level(lvl_a), .edge_pulse(pls_a), .sticky(stk_a), .evt_count(cnt_a));
  multi_edge_sync #(.NUM_CH(1), .SYNC_STAGES(3), .FILTER_LEN(2), .EDGE_MODE(EDGE_BOTH), .CNT_W(8)) u_b (
    .outclk(clk), .rst_n(rst_n), .async_sig(a_drv[6]), .clr(cl_drv[6]), .cnt_clr(cc_drv[3]),
    .sync_level(lvl_b), .edge_pulse(pls_b), .sticky(stk_b), .evt_count(cnt_b));

  logic [6:0]  d_lvl, d_pls, d_stk;
  logic [35:0] d_cnt;
  assign d_lvl = {lvl_b, lvl_a, lvl_f, lvl_r};
  assign d_pls = {pls_b, pls_a, pls_f, pls_r};
  assign d_stk = {stk_b, stk_a, stk_f, stk_r};
  assign d_cnt = {cnt_b, cnt_a, cnt_f, cnt_r};

  // Reference model: sampled-input history, a window of the last observed
  // synchronised values, and a level that flips once the whole window disagrees.
  localparam int PS [7] = '{2, 2, 2, 2, 2, 2, 3};
  localparam int PF [7] = '{1, 1, 1, 1, 4, 1, 2};
  localparam int PW [7] = '{3, 3, 3, 3, 8, 8, 8};
  localparam int PM [7] = '{0, 0, 0, 0, 0, 1, 2};  // 0 rise, 1 fall, 2 both

  typedef struct {
    bit [15:0]   hist;
    bit [15:0]   obs;
    bit          level;
    bit          pulse;
    bit          sticky;
    int unsigned cnt;
  } mch_t;

  mch_t m [7];

  function automatic mch_t step(mch_t x, bit a, bit cl, bit cc, int c);
    mch_t y;
    bit   sl;
    bit   acc;
    y       = x;
    y.pulse = 1'b0;
    sl      = x.hist[PS[c]-1];
    y.hist  = {x.hist[14:0], a};
    y.obs   = {x.obs[14:0], sl};
    acc     = 1'b1;
    for (int i = 0; i < PF[c]; i++) if (y.obs[i] == x.level) acc = 1'b0;
    if (acc) begin
      y.level = ~x.level;
      y.pulse = (PM[c] == 2) || (PM[c] == 0 && y.level) || (PM[c] == 1 && !y.level);
    end
    y.sticky = y.pulse | (x.sticky & ~cl);
    if (cc) y.cnt = y.pulse ? 1 : 0;
    else if (y.pulse && x.cnt < (1 << PW[c]) - 1) y.cnt = x.cnt + 1;
    return y;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 7; c++) m[c] <= '{default: 0};
    end else begin
      for (int c = 0; c < 7; c++)
        m[c] <= step(m[c], a_drv[c], cl_drv[c], (c < 4) ? cc_drv[0] : cc_drv[c-3], c);
    end
  end

  logic [6:0]  m_lvl, m_pls, m_stk;
  logic [35:0] m_cnt;
  always_comb begin
    m_lvl = '0; m_pls = '0; m_stk = '0; m_cnt = '0;
    for (int c = 0; c < 7; c++) begin
      m_lvl[c] = m[c].level;
      m_pls[c] = m[c].pulse;
      m_stk[c] = m[c].sticky;
    end
    for (int c = 0; c < 4; c++) m_cnt[c*3 +: 3] = m[c].cnt[2:0];
    for (int c = 4; c < 7; c++) m_cnt[12 + (c-4)*8 +: 8] = m[c].cnt[7:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    a_drv = '0; cl_drv = '0; cc_drv = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_lvl, d_pls, d_stk, d_cnt} !== 57'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0", {d_lvl, d_pls, d_stk, d_cnt});
    end
  endtask

  task automatic test_latency;
    do_reset();
    a_drv[0] = 1'b1;
    cyc(2);
    checks++;
    if (lvl_r[0] !== 1'b0) begin
      errors++; $display("FAIL latency_early got %b exp 0", lvl_r[0]);
    end
    cyc(1);
    checks++;
    if ({lvl_r[0], pls_r[0]} !== 2'b11) begin
      errors++; $display("FAIL latency_edge3 got %b exp 11", {lvl_r[0], pls_r[0]});
    end
    cyc(1);
    checks++;
    if ({pls_r[0], stk_r[0], cnt_r[2:0]} !== {1'b0, 1'b1, 3'd1}) begin
      errors++; $display("FAIL latency_edge4 got %b exp 0_1_001", {pls_r[0], stk_r[0], cnt_r[2:0]});
    end
    checks++;
    if ({d_lvl, d_pls, d_stk, d_cnt} !== {m_lvl, m_pls, m_stk, m_cnt}) begin
      errors++; $display("FAIL latency_model got %h exp %h", {d_lvl, d_pls, d_stk, d_cnt}, {m_lvl, m_pls, m_stk, m_cnt});
    end
  endtask

  task automatic test_filter;
    int seen = 0;
    int n_pls = 0;
    int at_edge = -1;
    do_reset();
    a_drv[4] = 1'b1;
    cyc(3);
    a_drv[4] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      seen += int'(pls_f) + int'(lvl_f);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL filter_glitch got %0d exp 0", seen);
    end
    a_drv[4] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (pls_f) begin n_pls++; at_edge = k; end
      checks++;
      if ({d_lvl, d_pls, d_stk, d_cnt} !== {m_lvl, m_pls, m_stk, m_cnt}) begin
        errors++; $display("FAIL filter_model got %h exp %h", {d_lvl, d_pls, d_stk, d_cnt}, {m_lvl, m_pls, m_stk, m_cnt});
      end
    end
    a_drv[4] = 1'b0;
    cyc(12);
    checks++;
    if (n_pls !== 1 || at_edge !== 6) begin
      errors++; $display("FAIL filter_pulse got n=%0d edge=%0d exp n=1 edge=6", n_pls, at_edge);
    end
    checks++;
    if (cnt_f !== 8'd1) begin
      errors++; $display("FAIL filter_count got %0d exp 1", cnt_f);
    end
  endtask

  task automatic test_edge_modes;
    int n_r = 0;
    int n_a = 0;
    int n_b = 0;
    do_reset();
    for (int k = 0; k < 38; k++) begin
      if (k < 30) begin
        a_drv[1] = ((k % 6) < 3);
        a_drv[5] = ((k % 6) < 3);
        a_drv[6] = ((k % 6) < 3);
      end
      cyc(1);
      n_r += int'(pls_r[1]);
      n_a += int'(pls_a);
      n_b += int'(pls_b);
      checks++;
      if ({d_lvl, d_pls, d_stk, d_cnt} !== {m_lvl, m_pls, m_stk, m_cnt}) begin
        errors++; $display("FAIL modes_model got %h exp %h", {d_lvl, d_pls, d_stk, d_cnt}, {m_lvl, m_pls, m_stk, m_cnt});
      end
    end
    checks++;
    if (n_r !== 5 || n_a !== 5 || n_b !== 10) begin
      errors++; $display("FAIL modes_pulses got %0d/%0d/%0d exp 5/5/10", n_r, n_a, n_b);
    end
    checks++;
    if ({cnt_r[5:3], cnt_a, cnt_b} !== {3'd5, 8'd5, 8'd10}) begin
      errors++; $display("FAIL modes_counts got %0d/%0d/%0d exp 5/5/10", cnt_r[5:3], cnt_a, cnt_b);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      a_drv[2] = 1'b1; cyc(2);
      a_drv[2] = 1'b0; cyc(2);
    end
    cyc(4);
    checks++;
    if (cnt_r[8:6] !== 3'd7) begin
      errors++; $display("FAIL sat_count got %0d exp 7", cnt_r[8:6]);
    end
    cl_drv[2] = 1'b1; cyc(1); cl_drv[2] = 1'b0;
    checks++;
    if (stk_r[2] !== 1'b0) begin
      errors++; $display("FAIL sat_clr_alone got %b exp 0", stk_r[2]);
    end
    a_drv[2] = 1'b1;
    cyc(2);
    cc_drv[0] = 1'b1; cl_drv[2] = 1'b1;
    cyc(1);
    cc_drv[0] = 1'b0; cl_drv[2] = 1'b0;
    checks++;
    if ({pls_r[2], stk_r[2], cnt_r[8:6]} !== {1'b1, 1'b1, 3'd1}) begin
      errors++; $display("FAIL sat_collision got %b exp 1_1_001", {pls_r[2], stk_r[2], cnt_r[8:6]});
    end
    cc_drv[0] = 1'b1; cyc(1); cc_drv[0] = 1'b0;
    checks++;
    if (cnt_r[8:6] !== 3'd0) begin
      errors++; $display("FAIL sat_cntclr_alone got %0d exp 0", cnt_r[8:6]);
    end
    a_drv[2] = 1'b0;
    cyc(3);
    checks++;
    if ({d_lvl, d_pls, d_stk, d_cnt} !== {m_lvl, m_pls, m_stk, m_cnt}) begin
      errors++; $display("FAIL sat_model got %h exp %h", {d_lvl, d_pls, d_stk, d_cnt}, {m_lvl, m_pls, m_stk, m_cnt});
    end
  endtask

  task automatic test_multi;
    do_reset();
    a_drv[3:0] = 4'b0101;
    cyc(3);
    checks++;
    if ({pls_r, lvl_r} !== 8'b0101_0101) begin
      errors++; $display("FAIL multi_same_cycle got %b exp 01010101", {pls_r, lvl_r});
    end
    cyc(1);
    checks++;
    if ({pls_r, stk_r} !== 8'b0000_0101) begin
      errors++; $display("FAIL multi_after got %b exp 00000101", {pls_r, stk_r});
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    a_drv[0] = 1'b1;
    cyc(4);
    a_drv[4] = 1'b1;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_lvl, d_pls, d_stk, d_cnt} !== 57'd0) begin
      errors++; $display("FAIL reset_mid got %h exp 0", {d_lvl, d_pls, d_stk, d_cnt});
    end
    @(negedge clk);
    a_drv = 7'b000_1000;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if (pls_r[3] !== 1'b0) begin
      errors++; $display("FAIL reset_rel_early got %b exp 0", pls_r[3]);
    end
    cyc(1);
    checks++;
    if ({pls_r, lvl_r} !== 8'b1000_1000) begin
      errors++; $display("FAIL reset_rel_event got %b exp 10001000", {pls_r, lvl_r});
    end
    checks++;
    if ({d_lvl, d_pls, d_stk, d_cnt} !== {m_lvl, m_pls, m_stk, m_cnt}) begin
      errors++; $display("FAIL reset_model got %h exp %h", {d_lvl, d_pls, d_stk, d_cnt}, {m_lvl, m_pls, m_stk, m_cnt});
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < 7; c++) begin
        if ($urandom_range(0, 3) == 0) a_drv[c] = ~a_drv[c];
        cl_drv[c] = ($urandom_range(0, 7) == 0);
      end
      for (int j = 0; j < 4; j++) cc_drv[j] = ($urandom_range(0, 15) == 0);
      cyc(1);
      checks++;
      if ({d_lvl, d_pls, d_stk, d_cnt} !== {m_lvl, m_pls, m_stk, m_cnt}) begin
        errors++; $display("FAIL random_model cyc %0d got %h exp %h", k, {d_lvl, d_pls, d_stk, d_cnt}, {m_lvl, m_pls, m_stk, m_cnt});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_filter();
    test_edge_modes();
    test_saturation();
    test_multi();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
